// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH JK flip-flops with parallel load, clock enable, and up-count, down-count and rotate-left word modes.
// Latency: new q/q_n/chg one clock after the sampling edge; tc is combinational (zero cycles) from q and mode.
// Backpressure: none; the register accepts an update on every rising edge; load overrides en, and en=0 holds q.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset; forces q=RESET_VAL, chg=0
//   en           clock enable for JK / count / rotate updates
//   load         synchronous parallel load of d (ignores en, mode, j, k)
//   d[W]         parallel load data
//   mode[2]      00 JK, 01 up-count, 10 down-count, 11 rotate-left
//   j[W], k[W]   per-bit JK controls, used only in mode 00
//   q[W]         register state
//   q_n[W]       always exactly ~q (derived, never stored separately)
//   tc           terminal count: all-ones in up mode, zero in down mode
//   chg          registered; high for one cycle after an edge that changed q
//
// WIDTH is meant to be 2..32. Rotate needs at least two bits, and 32 keeps
// cascades of banks the natural way to build wider counters.
module jk_reg_bank #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             chg
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_ROTL = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  mode_t            mode_sel;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] jk_nxt;
  logic [WIDTH-1:0] up_nxt;
  logic [WIDTH-1:0] down_nxt;
  logic [WIDTH-1:0] rotl_nxt;
  logic [WIDTH-1:0] mode_nxt;

  assign mode_sel = mode_t'(mode);

  // Per-bit JK next state, written as the classic characteristic equation:
  //   q+ = (j & ~q) | (~k & q)
  // which covers hold (00), set (10), clear (01) and toggle (11) in one term.
  assign jk_nxt = (j & ~q_reg) | (~k & q_reg);

  // Word modes. Addition/subtraction are truncated to WIDTH bits, so the
  // all-ones -> 0 and 0 -> all-ones wraps come for free.
  assign up_nxt   = q_reg + ONE;
  assign down_nxt = q_reg - ONE;
  assign rotl_nxt = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};

  always_comb begin
    mode_nxt = q_reg;
    unique case (mode_sel)
      MODE_JK:   mode_nxt = jk_nxt;
      MODE_UP:   mode_nxt = up_nxt;
      MODE_DOWN: mode_nxt = down_nxt;
      MODE_ROTL: mode_nxt = rotl_nxt;
      default:   mode_nxt = q_reg;
    endcase
  end

  // Update priority: load beats enable, enable gates every mode.
  always_comb begin
    q_nxt = q_reg;
    if (load) begin
      q_nxt = d;
    end else if (en) begin
      q_nxt = mode_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= RESET_VAL;
      chg   <= 1'b0;
    end else begin
      q_reg <= q_nxt;
      // Compare against the value actually being written, so a reload of the
      // held value or an all-hold JK pattern reports no change.
      chg   <= (q_nxt != q_reg);
    end
  end

  assign q   = q_reg;
  assign q_n = ~q_reg;

  // Terminal count ignores en and load so a downstream bank can use
  // (tc & en) as its own enable on the very next edge.
  always_comb begin
    tc = 1'b0;
    unique case (mode_sel)
      MODE_UP:   tc = (q_reg == ALL_ONES);
      MODE_DOWN: tc = (q_reg == ZERO);
      default:   tc = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
module tb_jk_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [1:0]  mode;

  logic [3:0]  d4, j4, k4, q4, qn4;
  logic        tc4, chg4;

  logic [1:0]  d2, j2, k2, q2, qn2;
  logic        tc2, chg2;

  logic [31:0] d32, j32, k32, q32, qn32;
  logic        tc32, chg32;

  int checks;
  int errors;

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'b0101)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .d(d4), .mode(mode),
    .j(j4), .k(k4), .q(q4), .q_n(qn4), .tc(tc4), .chg(chg4)
  );

  jk_reg_bank #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .d(d2), .mode(mode),
    .j(j2), .k(k2), .q(q2), .q_n(qn2), .tc(tc2), .chg(chg2)
  );

  jk_reg_bank #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .d(d32), .mode(mode),
    .j(j32), .k(k32), .q(q32), .q_n(qn32), .tc(tc32), .chg(chg32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle, so inputs change and outputs are
  // sampled away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    load   = 1'b0;
    mode   = 2'b01;
    d4 = '0;  j4 = '0;  k4 = '0;
    d2 = '0;  j2 = '0;  k2 = '0;
    d32 = '0; j32 = '0; k32 = '0;

    // Reset held while the clock runs with count enabled.
    repeat (3) step();
    chk("rst_q",   32'(q4),   32'h5);
    chk("rst_qn",  32'(qn4),  32'hA);
    chk("rst_chg", 32'(chg4), 32'h0);
    rst_n = 1'b1;

    // JK per-bit: start from 0011.
    load = 1'b1; d4 = 4'b0011; mode = 2'b00;
    step();
    chk("load0011_q",   32'(q4),   32'h3);
    chk("load0011_chg", 32'(chg4), 32'h1);
    load = 1'b0; en = 1'b1; j4 = 4'b1010; k4 = 4'b0110;
    step();
    chk("jk_q",   32'(q4),   32'h9);
    chk("jk_qn",  32'(qn4),  32'h6);
    chk("jk_chg", 32'(chg4), 32'h1);
    chk("jk_tc",  32'(tc4),  32'h0);
    j4 = 4'b0000; k4 = 4'b0000;
    step();
    chk("jkhold_q",   32'(q4),   32'h9);
    chk("jkhold_chg", 32'(chg4), 32'h0);

    // Up-count wrap.
    load = 1'b1; d4 = 4'b1110;
    step();
    load = 1'b0; mode = 2'b01;
    #1;
    chk("up_tc_1110", 32'(tc4), 32'h0);
    step();
    chk("up1_q",  32'(q4),  32'hF);
    chk("up1_tc", 32'(tc4), 32'h1);
    step();
    chk("up2_q",   32'(q4),   32'h0);
    chk("up2_tc",  32'(tc4),  32'h0);
    chk("up2_chg", 32'(chg4), 32'h1);
    step();
    chk("up3_q", 32'(q4), 32'h1);

    // Down-count wrap, then hold with en=0.
    load = 1'b1; d4 = 4'b0001; mode = 2'b10;
    step();
    chk("dn_load_q",  32'(q4),  32'h1);
    chk("dn_load_tc", 32'(tc4), 32'h0);
    load = 1'b0;
    step();
    chk("dn1_q",  32'(q4),  32'h0);
    chk("dn1_tc", 32'(tc4), 32'h1);
    step();
    chk("dn2_q",   32'(q4),   32'hF);
    chk("dn2_tc",  32'(tc4),  32'h0);
    chk("dn2_chg", 32'(chg4), 32'h1);
    en = 1'b0;
    step();
    chk("hold1_q",   32'(q4),   32'hF);
    chk("hold1_chg", 32'(chg4), 32'h0);
    step();
    chk("hold2_q",   32'(q4),   32'hF);
    chk("hold2_chg", 32'(chg4), 32'h0);

    // tc follows mode combinationally with q=1111.
    mode = 2'b01; #1;
    chk("tc_mode_up",   32'(tc4), 32'h1);
    mode = 2'b11; #1;
    chk("tc_mode_rotl", 32'(tc4), 32'h0);
    mode = 2'b00; #1;
    chk("tc_mode_jk",   32'(tc4), 32'h0);

    // Rotate-left, then load beats a simultaneous count.
    en = 1'b1; load = 1'b1; d4 = 4'b1000; mode = 2'b11;
    step();
    load = 1'b0;
    step();
    chk("rot1_q", 32'(q4), 32'h1);
    step();
    chk("rot2_q", 32'(q4), 32'h2);
    load = 1'b1; d4 = 4'b0110; en = 1'b1; mode = 2'b01;
    step();
    chk("prio_q", 32'(q4), 32'h6);
    // Reload of the same value: no change reported.
    step();
    chk("reload_q",   32'(q4),   32'h6);
    chk("reload_chg", 32'(chg4), 32'h0);

    // Asynchronous reset between edges while counting.
    load = 1'b0; en = 1'b1; mode = 2'b01;
    step();
    chk("cnt_q", 32'(q4), 32'h7);
    rst_n = 1'b0;
    #1;
    chk("arst_q",   32'(q4),   32'h5);
    chk("arst_chg", 32'(chg4), 32'h0);
    #1;
    rst_n = 1'b1;
    // First edge after release performs a normal increment.
    step();
    chk("rel_q",   32'(q4),   32'h6);
    chk("rel_chg", 32'(chg4), 32'h1);

    // Width generality: 2 and 32 bits, up-count from all-ones.
    load = 1'b1; d2 = 2'b11; d32 = 32'hFFFF_FFFF; mode = 2'b01;
    step();
    load = 1'b0;
    #1;
    chk("w2_tc_pre",  32'(tc2),  32'h1);
    chk("w32_tc_pre", 32'(tc32), 32'h1);
    step();
    chk("w2_q",    32'(q2),   32'h0);
    chk("w2_tc",   32'(tc2),  32'h0);
    chk("w2_qn",   32'(qn2),  32'h3);
    chk("w32_q",   q32,       32'h0);
    chk("w32_tc",  32'(tc32), 32'h0);
    chk("w32_qn",  qn32,      32'hFFFF_FFFF);
    chk("w32_chg", 32'(chg32), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised bank of WIDTH JK flip-flops sharing one clock and an asynchronous active-low reset. It is the multi-bit, multi-mode successor to the single-bit JK flip-flop. Per-bit JK behaviour is retained, and the bank adds parallel load, clock enable, and three whole-word modes: up-count, down-count and rotate. It sits wherever the design needs a small control/status register or a counter built on JK semantics.

## Interface
- `WIDTH`, default 8: number of flip-flops; legal range 2..32.
- `RESET_VAL`, default 0: value loaded into `q` on reset (WIDTH bits).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `en` in 1: clock enable for JK, count and rotate updates.
- `load` in 1: synchronous parallel load of `d`; ignores `en`.
- `d` in WIDTH: parallel load data.
- `mode` in 2: 00 JK, 01 up-count, 10 down-count, 11 rotate-left.
- `j` in WIDTH: per-bit J inputs; used in mode 00 only.
- `k` in WIDTH: per-bit K inputs; used in mode 00 only.
- `q` out WIDTH: register state.
- `q_n` out WIDTH: bitwise complement of `q`, always exactly `~q`.
- `tc` out 1: terminal count, combinational from `q` and `mode`.
- `chg` out 1: registered; high for one cycle after any edge where `q` changed value.

## Operation
- Reset: while `rst_n`=0, `q`=RESET_VAL, `q_n`=~RESET_VAL and `chg`=0, independent of `clk`.
- Update priority at each rising edge (with `rst_n`=1), highest first:
  - `load`=1: `q` <= `d`. `mode`, `en`, `j` and `k` are ignored.
  - `en`=0: `q` holds.
  - `en`=1: `q` updates per `mode`.
- Mode 00, JK, evaluated independently per bit i:
  - j=0, k=0: hold.
  - j=1, k=0: set to 1.
  - j=0, k=1: clear to 0.
  - j=1, k=1: toggle.
- Mode 01, up-count: `q` <= `q`+1, modulo 2^WIDTH; all-ones wraps to 0. `j` and `k` are ignored.
- Mode 10, down-count: `q` <= `q`-1, modulo 2^WIDTH; 0 wraps to all-ones.
- Mode 11, rotate-left: `q` <= {q[WIDTH-2:0], q[WIDTH-1]}.
- `tc` = (mode==01 and q==all-ones) or (mode==10 and q==0); it is 0 in modes 00 and 11.
  - `tc` does not depend on `en` or `load`.
- `chg` <= (next `q` != current `q`).
  - A load of the value already held gives `chg`=0.
  - A JK pattern that holds every bit gives `chg`=0.
- Changing `mode` between edges has no effect on `q` until the next enabled edge. `tc` follows `mode` combinationally.

## Timing
- Latency: one clock from inputs sampled at an edge to the new `q`/`q_n`. `chg` is valid in the same cycle as that new `q`.
- `tc` has zero-cycle latency from `q`/`mode`. This lets a cascaded bank use `tc` & `en` as its own `en` for the next edge.
- Reset mid-operation: asserting `rst_n` forces `q` to RESET_VAL immediately (asynchronously). Any in-flight load or count is lost.
- Reset release: the first rising edge with `rst_n`=1 performs a normal update. No extra dead cycle.
- Simultaneous `load`=1 and `en`=1: load wins; count and JK are not applied.
- `q_n` is never a separately stored value that could diverge from `q`.

## Test plan
Benches run with WIDTH=4 unless stated.
- Reset: hold `rst_n`=0 with RESET_VAL=4'b0101 and toggle `clk` -> `q`=0101, `q_n`=1010, `chg`=0. Assert `rst_n`=0 between edges while counting -> `q` returns to 0101 before the next edge.
- JK per-bit: from `q`=0011, mode 00, `en`=1, `j`=1010, `k`=0110 -> `q`=1001 after one edge, `chg`=1. Then `j`=`k`=0000 -> `q` stays 1001, `chg`=0.
- Up-count wrap: load 1110, then mode 01 with `en`=1 for 3 edges -> `q` = 1111 (`tc`=1), 0000 (`tc`=0), 0001.
- Down-count wrap: load 0001, mode 10 -> `q` = 0000 (`tc`=1), then 1111. With `en`=0 for 2 edges, `q` holds 1111 and `chg`=0.
- Rotate and priority: load 1000, mode 11 -> `q` = 0001, 0010. Then `load`=1, `d`=0110, `en`=1, mode 01 on the same edge -> `q`=0110, with no increment.
- Width generality: WIDTH=2 and WIDTH=32 up-count from all-ones -> wraps to 0 with `tc`=1 in the cycle before the wrap edge.
